perf_event_monitor: RTL and testbench

- Synthesizable, parametrised performance-event counter bank that sits beside the pipelined cpu.
- Counts per-cycle event strobes such as retired instruction, I/D cache request and I/D cache hit.
- Also counts run cycles, freezes the whole bank on halt, and flags a watchdog timeout.
- Software or a debug port reads the counters through a registered select/read port.

---
 rtl/perf_event_monitor.sv | 153 +++++++++++++++
 tb/tb_perf_event_monitor.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_event_monitor.sv
// -----------------------------------------------------------------------------
// perf_event_monitor
//   Performance-event counter bank that sits beside the CPU pipeline. It counts
//   per-cycle event strobes and run cycles, freezes on processor halt and
//   flags a watchdog timeout. A registered select/read port exposes every
//   counter with one cycle of latency.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable (IDLE->RUN request, RUN->IDLE pause)
//   clr       in   synchronous clear of counters/flags, forces IDLE
//   evt       in   [NUM_EVT]   per-cycle event strobes, bit i -> counter i
//   halt      in   processor halt, freezes the bank
//   sat_mode  in   1 = saturate at max, 0 = wrap to 0
//   rd_sel    in   [SEL_W]     0..NUM_EVT-1 event counter, NUM_EVT cycle counter
//   rd_data   out  [CNT_W]     registered read data
//   ovf       out  [NUM_EVT+1] sticky overflow flags, bit NUM_EVT = cycle counter
//   state     out  [2]         0=IDLE 1=RUN 2=FROZEN 3=TIMEOUT
//   timeout   out  high while state is TIMEOUT
// -----------------------------------------------------------------------------
module perf_event_monitor #(
    parameter int          NUM_EVT    = 8,
    parameter int          CNT_W      = 32,
    parameter int unsigned WDOG_LIMIT = 100000,
    parameter int          SEL_W      = $clog2(NUM_EVT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               halt,
    input  logic               sat_mode,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic [NUM_EVT:0]   ovf,
    output logic [1:0]         state,
    output logic               timeout
);

    localparam int NUM_CNT = NUM_EVT + 1;
    localparam int CYC_IDX = NUM_EVT;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // The watchdog can only fire when its limit is nonzero and the cycle
    // counter is wide enough to ever reach it.
    localparam bit WDOG_ON = (WDOG_LIMIT != 0) &&
                             ((CNT_W >= 32) || (WDOG_LIMIT < (32'd1 << CNT_W)));
    localparam logic [CNT_W-1:0] WDOG_VAL = CNT_W'(WDOG_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        FROZEN  = 2'd2,
        TIMEOUT = 2'd3
    } monState_e;

    monState_e        curState;
    logic [CNT_W-1:0] cnt     [NUM_CNT];
    logic [CNT_W-1:0] cntNext [NUM_CNT];
    logic [NUM_EVT:0] incReq;
    logic [NUM_EVT:0] ovfHit;
    logic             wdogHit;
    logic [CNT_W-1:0] rdMux;

    // The cycle counter sits at the top index and increments every RUN edge.
    assign incReq = {1'b1, evt};

    // Candidate counter values for a RUN edge, with saturate/wrap handling.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        ovfHit = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cntNext[i] = cnt[i];
            if (incReq[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    ovfHit[i]  = 1'b1;
                    cntNext[i] = sat_mode ? CNT_MAX : '0;
                end else begin
                    cntNext[i] = cnt[i] + 1'b1;
                end
            end
        end
        // Compared against the post-increment value so the limit cycle is
        // itself counted before the exit.
        wdogHit = WDOG_ON && (cntNext[CYC_IDX] == WDOG_VAL);
    end

    // Read mux over the pre-update counters; out-of-range selects read 0.
    always_comb begin
        rdMux = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rdMux = cnt[i];
            end
        end
    end

    assign state = curState;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the counter bank is built from flops rather than a RAM, so it
        // takes the asynchronous reset along with the rest of the state.
        if (!rst_n) begin
            curState <= IDLE;
            timeout  <= 1'b0;
            ovf      <= '0;
            rd_data  <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop updates from the
            // values held before this edge, independent of statement order.
            rd_data <= rdMux;
            if (clr) begin
                curState <= IDLE;
                timeout  <= 1'b0;
                ovf      <= '0;
                for (int i = 0; i < NUM_CNT; i++) begin
                    cnt[i] <= '0;
                end
            end else begin
                case (curState)
                    IDLE: begin
                        if (en) begin
                            curState <= RUN;
                        end
                    end
                    RUN: begin
                        cnt <= cntNext;
                        ovf <= ovf | ovfHit;
                        if (halt) begin
                            curState <= FROZEN;
                        end else if (wdogHit) begin
                            curState <= TIMEOUT;
                            timeout  <= 1'b1;
                        end else if (!en) begin
                            curState <= IDLE;
                        end
                    end
                    default: begin
                        // FROZEN and TIMEOUT hold until clr or reset.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_perf_event_monitor.sv
// -----------------------------------------------------------------------------
// tb_perf_event_monitor
//   Two monitors share one stimulus stream: A (4-bit counters, watchdog off)
//   exercises saturate/wrap, B (8-bit counters, watchdog limit 16) exercises
//   the watchdog. A table, directed sequences and a randomized phase are all
//   checked; the random phase uses a counting model kept as plain integers.
// -----------------------------------------------------------------------------
module tb_perf_event_monitor;

    localparam int NUM_EVT = 8;
    localparam int SEL_W   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic                 clr;
    logic [NUM_EVT-1:0]   evt;
    logic                 halt;
    logic                 sat_mode;
    logic [SEL_W-1:0]     rd_sel;

    logic [3:0]           rdA;
    logic [7:0]           rdB;
    logic [NUM_EVT:0]     ovfA, ovfB;
    logic [1:0]           stA, stB;
    logic                 toA, toB;

    always #5 clk = ~clk;

    perf_event_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(4), .WDOG_LIMIT(0)) dutA (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .evt(evt), .halt(halt),
        .sat_mode(sat_mode), .rd_sel(rd_sel), .rd_data(rdA), .ovf(ovfA),
        .state(stA), .timeout(toA)
    );

    perf_event_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(8), .WDOG_LIMIT(16)) dutB (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .evt(evt), .halt(halt),
        .sat_mode(sat_mode), .rd_sel(rd_sel), .rd_data(rdB), .ovf(ovfB),
        .state(stB), .timeout(toB)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model (index 0 = A, 1 = B) ----------------
    longint unsigned  mCnt [2][NUM_EVT+1];
    logic [NUM_EVT:0] mOvf [2];
    int               mSt  [2];
    longint unsigned  mRd  [2];

    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i <= NUM_EVT; i++) mCnt[k][i] = 0;
            mOvf[k] = '0;
            mSt[k]  = 0;
            mRd[k]  = 0;
        end
    endfunction

    // Applies the current inputs as one clock edge to both models.
    function automatic void modelEdge();
        logic [NUM_EVT:0] inc;
        longint unsigned  maxv;
        longint unsigned  lim;
        inc = {1'b1, evt};
        for (int k = 0; k < 2; k++) begin
            maxv = (k == 0) ? 15 : 255;
            lim  = (k == 0) ? 0 : 16;
            mRd[k] = (rd_sel <= NUM_EVT) ? mCnt[k][rd_sel] : 0;
            if (clr) begin
                for (int i = 0; i <= NUM_EVT; i++) mCnt[k][i] = 0;
                mOvf[k] = '0;
                mSt[k]  = 0;
            end else if (mSt[k] == 0) begin
                if (en) mSt[k] = 1;
            end else if (mSt[k] == 1) begin
                for (int i = 0; i <= NUM_EVT; i++) begin
                    if (inc[i]) begin
                        if (mCnt[k][i] == maxv) begin
                            mOvf[k][i] = 1'b1;
                            if (!sat_mode) mCnt[k][i] = 0;
                        end else begin
                            mCnt[k][i] = mCnt[k][i] + 1;
                        end
                    end
                end
                if (halt) mSt[k] = 2;
                else if (lim != 0 && mCnt[k][NUM_EVT] == lim) mSt[k] = 3;
                else if (!en) mSt[k] = 0;
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        modelEdge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmpModel(input string tag);
        check({tag, ".A.state"},   64'(stA),  64'(mSt[0]));
        check({tag, ".A.timeout"}, 64'(toA),  64'(mSt[0] == 3));
        check({tag, ".A.ovf"},     64'(ovfA), 64'(mOvf[0]));
        check({tag, ".A.rd"},      64'(rdA),  mRd[0]);
        check({tag, ".B.state"},   64'(stB),  64'(mSt[1]));
        check({tag, ".B.timeout"}, 64'(toB),  64'(mSt[1] == 3));
        check({tag, ".B.ovf"},     64'(ovfB), 64'(mOvf[1]));
        check({tag, ".B.rd"},      64'(rdB),  mRd[1]);
    endtask

    task automatic checkZeroOutputs(input string tag);
        check({tag, ".A.rd"},    64'(rdA),  64'd0);
        check({tag, ".A.ovf"},   64'(ovfA), 64'd0);
        check({tag, ".A.state"}, 64'(stA),  64'd0);
        check({tag, ".A.to"},    64'(toA),  64'd0);
        check({tag, ".B.rd"},    64'(rdB),  64'd0);
        check({tag, ".B.ovf"},   64'(ovfB), 64'd0);
        check({tag, ".B.state"}, 64'(stB),  64'd0);
        check({tag, ".B.to"},    64'(toB),  64'd0);
    endtask

    task automatic doClr();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    // ---------------- table for the basic count/freeze sequence ----------------
    typedef struct packed {
        logic       en;
        logic       evt0;
        logic       halt;
        logic [3:0] sel;
        logic [1:0] expState;
        logic [7:0] expRd;
    } vec_t;

    vec_t t1 [14];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        logic [7:0] prev;

        rst_n = 1'b1; en = 1'b0; clr = 1'b0; evt = '0; halt = 1'b0;
        sat_mode = 1'b1; rd_sel = '0;

        // ---- reset state ----
        @(negedge clk);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkZeroOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ---- 10 RUN cycles, evt[0] on 5, halt on the 10th, then frozen ----
        //             en    evt0  halt  sel     st     rd
        t1[0]  = '{1'b1, 1'b0, 1'b0, 4'd8, 2'd1, 8'd0};
        t1[1]  = '{1'b1, 1'b1, 1'b0, 4'd8, 2'd1, 8'd0};
        t1[2]  = '{1'b1, 1'b0, 1'b0, 4'd8, 2'd1, 8'd1};
        t1[3]  = '{1'b1, 1'b1, 1'b0, 4'd8, 2'd1, 8'd2};
        t1[4]  = '{1'b1, 1'b0, 1'b0, 4'd8, 2'd1, 8'd3};
        t1[5]  = '{1'b1, 1'b1, 1'b0, 4'd8, 2'd1, 8'd4};
        t1[6]  = '{1'b1, 1'b0, 1'b0, 4'd8, 2'd1, 8'd5};
        t1[7]  = '{1'b1, 1'b1, 1'b0, 4'd8, 2'd1, 8'd6};
        t1[8]  = '{1'b1, 1'b0, 1'b0, 4'd8, 2'd1, 8'd7};
        t1[9]  = '{1'b1, 1'b1, 1'b0, 4'd8, 2'd1, 8'd8};
        t1[10] = '{1'b1, 1'b0, 1'b1, 4'd0, 2'd2, 8'd5};
        t1[11] = '{1'b1, 1'b1, 1'b0, 4'd8, 2'd2, 8'd10};
        t1[12] = '{1'b0, 1'b1, 1'b0, 4'd0, 2'd2, 8'd5};
        t1[13] = '{1'b1, 1'b1, 1'b1, 4'd0, 2'd2, 8'd5};
        for (int i = 0; i < 14; i++) begin
            en     = t1[i].en;
            evt    = {7'd0, t1[i].evt0};
            halt   = t1[i].halt;
            rd_sel = t1[i].sel;
            cycle();
            check($sformatf("t1[%0d].A.state", i), 64'(stA), 64'(t1[i].expState));
            check($sformatf("t1[%0d].B.state", i), 64'(stB), 64'(t1[i].expState));
            check($sformatf("t1[%0d].A.rd", i),    64'(rdA), 64'(t1[i].expRd));
            check($sformatf("t1[%0d].B.rd", i),    64'(rdB), 64'(t1[i].expRd));
            check($sformatf("t1[%0d].B.to", i),    64'(toB), 64'd0);
        end
        halt = 1'b0; en = 1'b0; evt = '0;

        // ---- saturate then wrap on the 4-bit instance ----
        for (int pass = 0; pass < 2; pass++) begin
            doClr();
            sat_mode = (pass == 0);
            en = 1'b1;
            cycle();
            evt = 8'h02;
            for (int i = 0; i < 20; i++) begin
                halt = (i == 19);
                cycle();
            end
            evt = '0; halt = 1'b0; rd_sel = 4'd1;
            cycle();
            check($sformatf("t2[%0d].A.cnt1", pass), 64'(rdA), (pass == 0) ? 64'd15 : 64'd4);
            check($sformatf("t2[%0d].A.ovf", pass),  64'(ovfA), 64'h102);
            cmpModel($sformatf("t2[%0d]", pass));
            rd_sel = 4'd8;
            cycle();
            check($sformatf("t2[%0d].A.cycle", pass), 64'(rdA), (pass == 0) ? 64'd15 : 64'd4);
            cmpModel($sformatf("t2c[%0d]", pass));
        end
        sat_mode = 1'b1;

        // ---- watchdog on B after 16 counted cycles ----
        en = 1'b0;
        doClr();
        en = 1'b1; rd_sel = 4'd8;
        cycle();
        n = 0;
        while (stB != 2'd3 && n < 40) begin
            evt = 8'($urandom);
            cycle();
            n++;
        end
        evt = '0;
        check("t3.runEdges", 64'(n), 64'd16);
        check("t3.B.state", 64'(stB), 64'd3);
        check("t3.B.timeout", 64'(toB), 64'd1);
        cycle();
        check("t3.B.cycle", 64'(rdB), 64'd16);
        cmpModel("t3");
        en = 1'b0;
        doClr();
        check("t3clr.B.state", 64'(stB), 64'd0);
        check("t3clr.B.timeout", 64'(toB), 64'd0);
        check("t3clr.B.ovf", 64'(ovfB), 64'd0);
        for (int s = 0; s <= NUM_EVT; s++) begin
            rd_sel = SEL_W'(s);
            cycle();
            check($sformatf("t3clr.B.cnt%0d", s), 64'(rdB), 64'd0);
            check($sformatf("t3clr.A.cnt%0d", s), 64'(rdA), 64'd0);
        end

        // ---- halt coincident with watchdog hit: FROZEN wins ----
        en = 1'b1;
        cycle();
        for (int i = 0; i < 16; i++) begin
            halt = (i == 15);
            cycle();
        end
        halt = 1'b0;
        check("t4.B.state", 64'(stB), 64'd2);
        check("t4.B.timeout", 64'(toB), 64'd0);
        rd_sel = 4'd8;
        cycle();
        check("t4.B.cycle", 64'(rdB), 64'd16);

        // ---- clr beats evt/halt/en in RUN ----
        doClr();
        en = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            evt = 8'($urandom);
            cycle();
        end
        clr = 1'b1; evt = 8'hFF; halt = 1'b1; en = 1'b1;
        cycle();
        clr = 1'b0; evt = '0; halt = 1'b0; en = 1'b0;
        check("t5.A.state", 64'(stA), 64'd0);
        check("t5.B.state", 64'(stB), 64'd0);
        check("t5.A.ovf", 64'(ovfA), 64'd0);
        check("t5.B.ovf", 64'(ovfB), 64'd0);
        for (int s = 0; s <= NUM_EVT; s++) begin
            rd_sel = SEL_W'(s);
            cycle();
            check($sformatf("t5.B.cnt%0d", s), 64'(rdB), 64'd0);
            cmpModel($sformatf("t5[%0d]", s));
        end

        // ---- asynchronous reset between edges, mid-RUN ----
        en = 1'b1; rd_sel = 4'd8;
        cycle();
        for (int i = 0; i < 3; i++) begin
            evt = 8'($urandom);
            cycle();
        end
        check("t6.pre.A.state", 64'(stA), 64'd1);
        check("t6.pre.B.rd", 64'(rdB), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkZeroOutputs("t6");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0; evt = '0;

        // ---- read latency on the cycle counter, out-of-range selects ----
        en = 1'b1; rd_sel = 4'd8;
        cycle();
        cycle();
        prev = rdB;
        check("t7.start", 64'(prev), 64'd0);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check($sformatf("t7.lag[%0d]", i), 64'(rdB), 64'(prev) + 64'd1);
            prev = rdB;
        end
        rd_sel = 4'd9;
        cycle();
        check("t7.sel9.A", 64'(rdA), 64'd0);
        check("t7.sel9.B", 64'(rdB), 64'd0);
        rd_sel = 4'd15;
        cycle();
        check("t7.sel15.B", 64'(rdB), 64'd0);
        cmpModel("t7");

        // ---- randomized stimulus against the model ----
        doClr();
        for (int i = 0; i < 500; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            clr      = ($urandom_range(0, 24) == 0);
            halt     = ($urandom_range(0, 39) == 0);
            sat_mode = 1'($urandom);
            evt      = 8'($urandom);
            rd_sel   = 4'($urandom_range(0, 15));
            cycle();
            cmpModel($sformatf("rnd[%0d]", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
